// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 key-scheduling and decode FSMs.
//   S_DEPTH    - number of entries in s_memory (256)
//   DATA_W     - s_memory data/address width (8)
//   KEY_BYTES  - secret-key length in bytes (3)
//   KEY_WIDTH  - secret-key width in bits (24)
//   ksa_state_t - symbolic state names, used for the debug state output
//   key_byte() - select key byte idx, byte 0 being the most significant byte
package rc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int KEY_BYTES = 3;
  localparam int KEY_WIDTH = 24;

  // Number of states in the key-scheduling FSM; the RTL uses one bit per state.
  localparam int NUM_STATES = 13;

  // The enum value of each state is also its bit position in the one-hot
  // state register. ST_BAD is only ever reported for an unmapped encoding.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INIT   = 4'd1,
    ST_RD_I   = 4'd2,
    ST_WAIT_I = 4'd3,
    ST_LAT_I  = 4'd4,
    ST_CALC_J = 4'd5,
    ST_RD_J   = 4'd6,
    ST_WAIT_J = 4'd7,
    ST_LAT_J  = 4'd8,
    ST_WR_J   = 4'd9,
    ST_WR_I   = 4'd10,
    ST_NEXT   = 4'd11,
    ST_DONE   = 4'd12,
    ST_BAD    = 4'd15
  } ksa_state_t;

  // Byte idx of the key, MSB-first: idx 0 -> key[23:16].
  function automatic logic [7:0] key_byte(input logic [KEY_WIDTH-1:0] key,
                                          input logic [1:0]           idx);
    logic [KEY_WIDTH-1:0] shifted;
    shifted = key << (8 * int'(idx));
    return shifted[KEY_WIDTH-1 -: 8];
  endfunction

endpackage

// File: rtl/ksa_fsm_if.sv
// ksa_fsm_if: s_memory port bundle (256x8 RAM with a two-cycle read latency).
//   address      - RAM address, driven by the master
//   data_out     - RAM write data, driven by the master
//   write_enable - write strobe; the write commits on the rising edge where it is 1
//   data_in      - RAM read data (q), driven by the memory
// Modports: master (the FSM side), slave (the memory side).
interface ksa_fsm_if;
  import rc4_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              write_enable;
  logic [DATA_W-1:0] data_in;

  modport master (
    output address,
    output data_out,
    output write_enable,
    input  data_in
  );

  modport slave (
    input  address,
    input  data_out,
    input  write_enable,
    output data_in
  );

endinterface

// File: rtl/ksa_fsm.sv
// ksa_fsm: RC4 key-scheduling stage. Fills s_memory with the identity
// permutation (s[i] = i) and then runs the RC4 shuffle
// (j = j + s[i] + key[i mod KEY_BYTES]; swap s[i], s[j]).
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-high
//   start      - begin a schedule; only looked at in IDLE
//   secret_key - key, byte 0 = secret_key[KEY_WIDTH-1 -: 8]; must be held
//                stable from start until done (it is not latched)
//   done       - schedule complete, s_memory holds the permutation
//   state_dbg  - current state in symbolic form, for observation only
//   mem        - s_memory master port (address, data_out, write_enable, data_in)
//
// Handshake: start/done form a level handshake. A start seen high in IDLE
// launches one full schedule; done then stays high for as long as start is
// held high and falls in the cycle after start is seen low, returning to IDLE.
// A later start reruns the whole schedule from the identity fill.
//
// RAM timing: data_in carries the word addressed two cycles earlier, so each
// read is address, wait, latch. address/data_out/write_enable are decoded
// straight from the one-hot state bits and the datapath registers.
module ksa_fsm #(
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES,
  parameter int KEY_WIDTH = rc4_pkg::KEY_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_WIDTH-1:0]   secret_key,
  output logic                   done,
  output rc4_pkg::ksa_state_t    state_dbg,
  ksa_fsm_if.master              mem
);
  import rc4_pkg::*;

  // One-hot state encodings; bit n is set for the state whose enum value is n.
  localparam logic [NUM_STATES-1:0] S_IDLE   = 13'd1 << ST_IDLE;
  localparam logic [NUM_STATES-1:0] S_INIT   = 13'd1 << ST_INIT;
  localparam logic [NUM_STATES-1:0] S_RD_I   = 13'd1 << ST_RD_I;
  localparam logic [NUM_STATES-1:0] S_WAIT_I = 13'd1 << ST_WAIT_I;
  localparam logic [NUM_STATES-1:0] S_LAT_I  = 13'd1 << ST_LAT_I;
  localparam logic [NUM_STATES-1:0] S_CALC_J = 13'd1 << ST_CALC_J;
  localparam logic [NUM_STATES-1:0] S_RD_J   = 13'd1 << ST_RD_J;
  localparam logic [NUM_STATES-1:0] S_WAIT_J = 13'd1 << ST_WAIT_J;
  localparam logic [NUM_STATES-1:0] S_LAT_J  = 13'd1 << ST_LAT_J;
  localparam logic [NUM_STATES-1:0] S_WR_J   = 13'd1 << ST_WR_J;
  localparam logic [NUM_STATES-1:0] S_WR_I   = 13'd1 << ST_WR_I;
  localparam logic [NUM_STATES-1:0] S_NEXT   = 13'd1 << ST_NEXT;
  localparam logic [NUM_STATES-1:0] S_DONE   = 13'd1 << ST_DONE;

  localparam logic [1:0] KEY_IDX_LAST = 2'(KEY_BYTES - 1);

  logic [NUM_STATES-1:0] state_q, state_d;
  logic [7:0]            i_q, i_d;
  logic [7:0]            j_q, j_d;
  logic [7:0]            si_q, si_d;
  logic [7:0]            sj_q, sj_d;
  logic [1:0]            key_idx_q, key_idx_d;

  // Current key byte, MSB-first. Shifting left by whole bytes keeps the
  // selected byte at the top so the slice index stays constant.
  logic [KEY_WIDTH-1:0]  key_sh;
  logic [7:0]            key_b;

  assign key_sh = secret_key << (8 * key_idx_q);
  assign key_b  = key_sh[KEY_WIDTH-1 -: 8];

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    key_idx_d = key_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          i_d     = 8'd0;
        end
      end

      // Identity fill: one write per cycle; i wraps from 255 back to 0,
      // which is exactly the starting index of the shuffle.
      S_INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d   = S_RD_I;
          j_d       = 8'd0;
          key_idx_d = 2'd0;
        end
      end

      S_RD_I:   state_d = S_WAIT_I;
      S_WAIT_I: state_d = S_LAT_I;

      S_LAT_I: begin
        si_d    = mem.data_in;
        state_d = S_CALC_J;
      end

      S_CALC_J: begin
        j_d     = j_q + si_q + key_b;
        state_d = S_RD_J;
      end

      S_RD_J:   state_d = S_WAIT_J;
      S_WAIT_J: state_d = S_LAT_J;

      S_LAT_J: begin
        sj_d    = mem.data_in;
        state_d = S_WR_J;
      end

      // When i == j both writes land on the same word; WR_I writes sj_q,
      // which was read from that word, so the swap degenerates to a no-op.
      S_WR_J: state_d = S_WR_I;
      S_WR_I: state_d = S_NEXT;

      S_NEXT: begin
        if (i_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          i_d       = i_q + 8'd1;
          key_idx_d = (key_idx_q == KEY_IDX_LAST) ? 2'd0 : key_idx_q + 2'd1;
          state_d   = S_RD_I;
        end
      end

      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end

      // Any unmapped encoding (including all-zero) recovers to IDLE.
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      si_q      <= 8'd0;
      sj_q      <= 8'd0;
      key_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      key_idx_q <= key_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from individual state bits
  // ---------------------------------------------------------------------------
  logic       addr_is_i;
  logic       addr_is_j;
  logic [7:0] address_c;
  logic [7:0] data_out_c;
  logic       write_enable_c;

  assign addr_is_i = state_q[ST_INIT] | state_q[ST_RD_I] |
                     state_q[ST_WAIT_I] | state_q[ST_WR_I];
  assign addr_is_j = state_q[ST_RD_J] | state_q[ST_WAIT_J] | state_q[ST_WR_J];

  always_comb begin
    address_c = 8'd0;
    if (addr_is_i) begin
      address_c = i_q;
    end else if (addr_is_j) begin
      address_c = j_q;
    end
  end

  always_comb begin
    data_out_c = 8'd0;
    if (state_q[ST_INIT]) begin
      data_out_c = i_q;
    end else if (state_q[ST_WR_J]) begin
      data_out_c = si_q;
    end else if (state_q[ST_WR_I]) begin
      data_out_c = sj_q;
    end
  end

  assign write_enable_c = state_q[ST_INIT] | state_q[ST_WR_J] | state_q[ST_WR_I];

  assign mem.address      = address_c;
  assign mem.data_out     = data_out_c;
  assign mem.write_enable = write_enable_c;
  assign done             = state_q[ST_DONE];

  // ---------------------------------------------------------------------------
  // Symbolic state for observation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_dbg = ST_BAD;
    case (state_q)
      S_IDLE:   state_dbg = ST_IDLE;
      S_INIT:   state_dbg = ST_INIT;
      S_RD_I:   state_dbg = ST_RD_I;
      S_WAIT_I: state_dbg = ST_WAIT_I;
      S_LAT_I:  state_dbg = ST_LAT_I;
      S_CALC_J: state_dbg = ST_CALC_J;
      S_RD_J:   state_dbg = ST_RD_J;
      S_WAIT_J: state_dbg = ST_WAIT_J;
      S_LAT_J:  state_dbg = ST_LAT_J;
      S_WR_J:   state_dbg = ST_WR_J;
      S_WR_I:   state_dbg = ST_WR_I;
      S_NEXT:   state_dbg = ST_NEXT;
      S_DONE:   state_dbg = ST_DONE;
      default:  state_dbg = ST_BAD;
    endcase
  end

endmodule

// File: tb/tb_ksa_fsm.sv
// tb_ksa_fsm: bench for ksa_fsm with a behavioural s_memory, a reference
// RC4 key schedule that predicts every RAM write, and a write monitor that
// pops those predictions as the DUT issues writes.
module tb_ksa_fsm;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset      = 1'b1;
  logic                start      = 1'b0;
  logic [23:0]         secret_key = 24'h0;
  logic                done;
  rc4_pkg::ksa_state_t state_dbg;

  ksa_fsm_if mem_if ();

  ksa_fsm dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .done       (done),
    .state_dbg  (state_dbg),
    .mem        (mem_if)
  );

  // ---------------------------------------------------------------------------
  // Behavioural s_memory: registered address, registered output, so q shows
  // the word addressed two edges earlier. Writes commit on the edge.
  // ---------------------------------------------------------------------------
  logic [7:0] ram [256];
  logic [7:0] addr_r = 8'h0;
  logic [7:0] q_r    = 8'h0;

  always @(posedge clock) begin
    if (mem_if.write_enable) ram[mem_if.address] <= mem_if.data_out;
    addr_r <= mem_if.address;
    q_r    <= ram[addr_r];
  end
  assign mem_if.data_in = q_r;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];     // {address, data} of each expected write, in order
  logic [7:0]  gold [256];   // expected final s_memory
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference RC4 key schedule: plain array arithmetic, records the write
  // stream (256 identity writes, then j-write and i-write per iteration).
  task automatic build_expect(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] kb;
    logic [7:0] t;
    int j;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      s[i] = 8'(i);
      exp_q.push_back({8'(i), 8'(i)});
    end
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
      j  = (j + int'(s[i]) + int'(kb)) % 256;
      exp_q.push_back({8'(j), s[i]});
      exp_q.push_back({8'(i), s[j]});
      t    = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    for (int i = 0; i < 256; i++) gold[i] = s[i];
  endtask

  // ---------------------------------------------------------------------------
  // Write monitor
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    if (!reset && mem_if.write_enable) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: actual addr=%0h data=%0h required=no write at t=%0t",
                 mem_if.address, mem_if.data_out, $time);
      end else begin
        check("write_stream", {mem_if.address, mem_if.data_out}, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One complete schedule. Latency counts the edge that samples start as
  // clock 1; done must first read high after clock 2817 (1 + 256 + 2560).
  task automatic run(input logic [23:0] key, input bit hold);
    int cnt;
    int errs;
    build_expect(key);
    secret_key = key;
    start      = 1'b1;
    @(posedge clock); #1;
    cnt = 1;
    if (!hold) start = 1'b0;

    errs = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem_if.write_enable !== 1'b1 || mem_if.address !== 8'(k) ||
          mem_if.data_out !== 8'(k) || done !== 1'b0) errs++;
      @(posedge clock); #1;
      cnt++;
    end
    check("init_phase_errors", errs, 0);

    while (done !== 1'b1 && cnt < 3200) begin
      @(posedge clock); #1;
      cnt++;
    end
    check("done_latency", cnt, 2817);
    check("expected_writes_left", exp_q.size(), 0);

    errs = 0;
    for (int k = 0; k < 256; k++) if (ram[k] !== gold[k]) errs++;
    check("ram_bytes_wrong", errs, 0);

    if (!hold) begin
      @(posedge clock); #1;
      check("done_falls", done, 1'b0);
      check("back_to_idle", state_dbg, rc4_pkg::ST_IDLE);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"},      mem_if.address, 8'h00);
    check({tag, "_data_out"},     mem_if.data_out, 8'h00);
    check({tag, "_write_enable"}, mem_if.write_enable, 1'b0);
    check({tag, "_done"},         done, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int errs;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_outputs("reset");
    check("reset_state", state_dbg, rc4_pkg::ST_IDLE);

    // All-zero key: identity fill, and the i=0/j=0 self-swap.
    run(24'h000000, 1'b0);

    // MSB-first key bytes: second iteration must land on j = 0 + 1 + 2 = 3.
    run(24'h000249, 1'b0);

    // Abort partway through, then a clean run.
    build_expect(24'h5A5A5A);
    secret_key = 24'h5A5A5A;
    start      = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (999) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    check_reset_outputs("midrun_reset");
    check("midrun_reset_state", state_dbg, rc4_pkg::ST_IDLE);
    repeat (5) @(posedge clock);
    #1 check("idle_after_abort", state_dbg, rc4_pkg::ST_IDLE);
    run(24'h1234AB, 1'b0);

    // Hold start through done: no writes, done stays up.
    run(24'($urandom), 1'b1);
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (done !== 1'b1 || mem_if.write_enable !== 1'b0) errs++;
    end
    check("done_held_errors", errs, 0);
    start = 1'b0;
    @(posedge clock); #1;
    check("done_drop", done, 1'b0);
    check("idle_after_drop", state_dbg, rc4_pkg::ST_IDLE);

    // Re-pulse start with a few random keys.
    for (int n = 0; n < 2; n++) begin
      repeat ($urandom_range(1, 4)) @(posedge clock);
      #1 run(24'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ksa_fsm.md
Name: ksa_fsm

Overview:
- RC4 key-scheduling stage that fills the 256x8 working RAM (s_memory) before the PRGA decode FSM runs.
- Phase 1 writes s[i] = i for every entry. Phase 2 runs the RC4 shuffle (j = j + s[i] + key[i mod KEY_BYTES], then swap s[i] and s[j]).
- Sits directly upstream of the decode FSM. Its done output releases the decode FSM's start, and the top-level mux gives it the s_memory port while done is low.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes.
- KEY_WIDTH, 24, width of secret_key; must equal 8*KEY_BYTES.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin schedule; sampled only in IDLE.
- secret_key  in  KEY_WIDTH  key; byte 0 = secret_key[KEY_WIDTH-1 -: 8], MSB-first byte order.
- data_in  in  8  s_memory read data (q).
- address  out  8  s_memory address.
- data_out  out  8  s_memory write data.
- write_enable  out  1  s_memory write strobe.
- done  out  1  schedule complete; s_memory valid for the decode FSM.

Behaviour:
- Reset: one clocked cycle with reset high sends the FSM to IDLE and clears i, j, si_reg, sj_reg and key_idx to 0. All outputs read 0 after reset (address=0, data_out=0, write_enable=0, done=0).
- Reset mid-operation: abort immediately with no further writes; s_memory contents are undefined afterwards.
- RAM timing: read data is valid on data_in two clocks after address is driven (address cycle, wait cycle, latch cycle). A write commits on the edge where write_enable=1.
- write_enable is high only in INIT and the two write states. address and data_out are decoded from state plus registers, with no extra output register.
- secret_key must be held stable from start until done. It is not latched.
- IDLE: done=0. If start=1, go to INIT with i=0.
- INIT: address=i, data_out=i, write_enable=1, i increments. When i==255, go to RD_I with i wrapping to 0, j=0, key_idx=0. Phase 1 takes exactly 256 cycles.
- Shuffle loop, 10 cycles per iteration; all arithmetic is 8-bit mod 256:
  - RD_I: address=i.
  - WAIT_I: address=i.
  - LAT_I: si_reg <= data_in.
  - CALC_J: j <= j + si_reg + key_byte[key_idx].
  - RD_J: address=j.
  - WAIT_J: address=j.
  - LAT_J: sj_reg <= data_in.
  - WR_J: address=j, data_out=si_reg, write_enable=1.
  - WR_I: address=i, data_out=sj_reg, write_enable=1.
  - NEXT: if i==255 go to DONE. Otherwise i+1, key_idx = (key_idx==KEY_BYTES-1) ? 0 : key_idx+1, then RD_I.
- key_idx is a separate 2-bit mod-KEY_BYTES counter. It must not be computed as i % 3.
- i==j case: WR_J then WR_I both hit the same address. The final value equals the original s[i], which is a correct no-op swap.
- DONE: done=1, write_enable=0. Stay in DONE while start=1; when start=0, return to IDLE with done=0. A new start then reruns the full schedule from INIT.
- Latency: done first reads high exactly 2817 clocks after the edge that samples start=1 in IDLE (1 + 256 + 256*10).
- Encoding: the state register uses one-hot or output-encoded states, matching the decode FSM convention that outputs are decoded directly from state bits. No illegal-state lockup: any unmapped state returns to IDLE.

Decomposition:
- Shared package rc4_pkg holds:
  - S_DEPTH=256, DATA_W=8, KEY_BYTES=3, KEY_WIDTH=24;
  - ksa_state_t enum;
  - key_byte(key, idx) function.
- No sub-module. A single FSM plus datapath is sufficient.
- The s_memory port mux between ksa_fsm and decode_fsm lives at top level, not in this block.

Test Plan:
- INIT contents: reset, key=24'h000000, start=1. Monitor the first 256 writes: address==data_out==0..255 in order with write_enable=1 each cycle, and no writes occur during cycles 1-256 other than these.
- Full schedule, key=24'h000000: behavioural RAM model. At done, all 256 s_memory bytes equal the golden Python/SV RC4-KSA model. done rises exactly 2817 clocks after start is sampled.
- Key byte order, key=24'h000249: compare with the golden model. Also confirm the first CALC_J gives j = 0 + 0 + 8'h00 = 0, and the second gives j = 0 + 1 + 8'h02 = 3.
- Same-address swap, key=24'h000000: at i=0, j=0, WR_J and WR_I both address 0 with data 0. The final s[0] matches the golden model.
- Reset mid-run: assert reset at cycle 1000 for one clock. done=0, write_enable=0, address=0 next cycle. Restart with key=24'h1234AB; the final RAM matches the golden model for that key.
- Start handshake: hold start=1 after done; done stays 1 with no writes. Drop start: done=0 next cycle and the FSM is in IDLE. Re-pulse start: a second full run, done again after 2817 clocks.
